stream_response_checker: RTL and testbench

Simulation-side sink that closes the loop on a stimulus-driving tester: it accepts the output stream of a device under test over a valid/ready handshake, compares each beat against an internally generated expected sequence, counts mismatches, detects stalls via a timeout, and reports a final pass/fail verdict. It sits in the test harness next to the stimulus tester, on the DUT's output side, and is the block that decides when a run is finished.

---
 rtl/stream_response_checker_if.sv | 27 ++
 rtl/stream_response_checker.sv | 170 +++++++++++++++++
 tb/tb_stream_response_checker.sv | 220 ++++++++++++++++++++++
 3 files changed

// File: rtl/stream_response_checker_if.sv
// rtl/stream_response_checker_if.sv - valid/ready beat stream between a DUT output and the checker
//
// Signals:
//   in_valid  source -> checker  beat valid
//   in_ready  checker -> source  checker can take a beat this cycle
//   in_bits   source -> checker  beat data, WIDTH bits
// Modports: master (DUT side, drives the beat), slave (checker side, drives ready).

interface stream_response_checker_if #(
    parameter int WIDTH = 8
) ();
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_bits;

    modport master (
        output in_valid,
        output in_bits,
        input  in_ready
    );

    modport slave (
        input  in_valid,
        input  in_bits,
        output in_ready
    );
endinterface

// File: rtl/stream_response_checker.sv
// rtl/stream_response_checker.sv - sink that checks a DUT output stream against an arithmetic sequence
//
// Parameters: WIDTH (beat width), COUNT (beats per run), SEED (expected beat 0),
//             STEP (increment mod 2^WIDTH), TIMEOUT (idle cycles in RUN before abort).
// Ports:
//   clock          rising-edge clock
//   reset          synchronous, active-low
//   start          one-cycle pulse, starts a run from IDLE or DONE
//   in_stream      slave side of the beat stream (in_valid, in_ready, in_bits)
//   done           run finished (all beats seen or timed out)
//   pass           verdict, meaningful while done=1
//   timed_out      run ended by the idle timer
//   err_count      mismatch count, saturates at 255
//   first_err_idx  beat index of first mismatch, 16'hFFFF if none
//   beat_count     beats accepted in the current/last run
// Optional build macro: STREAM_CHECKER_STOP_EN - prints the verdict when done first
// rises and ends the simulation ($finish on pass, $fatal on fail). Ignored under SYNTHESIS.

module stream_response_checker #(
    parameter int WIDTH   = 8,
    parameter int COUNT   = 16,
    parameter int SEED    = 0,
    parameter int STEP    = 1,
    parameter int TIMEOUT = 256
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     start,
    stream_response_checker_if.slave in_stream,
    output logic                     done,
    output logic                     pass,
    output logic                     timed_out,
    output logic [7:0]               err_count,
    output logic [15:0]              first_err_idx,
    output logic [15:0]              beat_count
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [WIDTH-1:0] SEED_W       = WIDTH'(SEED);
    localparam logic [WIDTH-1:0] STEP_W       = WIDTH'(STEP);
    localparam logic [15:0]      LAST_IDX     = 16'(COUNT - 1);
    localparam logic [15:0]      TIMEOUT_LAST = 16'(TIMEOUT - 1);
    localparam logic [15:0]      NO_ERR_IDX   = 16'hFFFF;

    state_t           state_q;
    state_t           state_d;
    logic [WIDTH-1:0] expected_q;
    logic [15:0]      idle_timer_q;
    logic             timed_out_q;
    logic [7:0]       err_count_q;
    logic [15:0]      first_err_idx_q;
    logic [15:0]      beat_count_q;

    logic in_run;
    logic accept;
    logic mismatch;
    logic last_beat;
    logic timeout_hit;
    logic restart;

    // Ready comes from state alone so there is no in_valid -> in_ready path.
    assign in_run   = (state_q == RUN);
    assign accept   = in_stream.in_valid & in_run;
    assign mismatch = accept && (in_stream.in_bits != expected_q);
    assign last_beat = accept && (beat_count_q == LAST_IDX);
    // The timer only expires on a cycle with no accept, so a last beat landing
    // on the expiry cycle finishes the run cleanly.
    assign timeout_hit = in_run && !accept && (idle_timer_q == TIMEOUT_LAST);
    assign restart  = start && ((state_q == IDLE) || (state_q == DONE));

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = RUN;
                end
            end
            RUN: begin
                if (last_beat || timeout_hit) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                if (start) begin
                    state_d = RUN;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset || restart) begin
            expected_q      <= SEED_W;
            idle_timer_q    <= 16'd0;
            timed_out_q     <= 1'b0;
            err_count_q     <= 8'd0;
            first_err_idx_q <= NO_ERR_IDX;
            beat_count_q    <= 16'd0;
        end else if (in_run) begin
            if (accept) begin
                if (mismatch) begin
                    if (err_count_q != 8'hFF) begin
                        err_count_q <= err_count_q + 8'd1;
                    end
                    if (first_err_idx_q == NO_ERR_IDX) begin
                        first_err_idx_q <= beat_count_q;
                    end
                end
                expected_q   <= expected_q + STEP_W;
                beat_count_q <= beat_count_q + 16'd1;
                idle_timer_q <= 16'd0;
            end else begin
                idle_timer_q <= idle_timer_q + 16'd1;
                if (timeout_hit) begin
                    timed_out_q <= 1'b1;
                end
            end
        end
    end

    assign in_stream.in_ready = in_run;
    assign done               = (state_q == DONE);
    assign pass               = done && (err_count_q == 8'd0) && !timed_out_q;
    assign timed_out          = timed_out_q;
    assign err_count          = err_count_q;
    assign first_err_idx      = first_err_idx_q;
    assign beat_count         = beat_count_q;

`ifdef STREAM_CHECKER_STOP_EN
`ifndef SYNTHESIS
    // Remembers done from the previous cycle so the report fires once per rise.
    logic done_seen_q;

    always @(posedge clock) begin
        if (!reset) begin
            done_seen_q <= 1'b0;
        end else begin
            done_seen_q <= done;
            if (done && !done_seen_q) begin
                $display("stream_response_checker: pass=%0d err_count=%0d first_err_idx=%0h",
                         pass, err_count, first_err_idx);
                if (pass) begin
                    $finish;
                end else begin
                    $fatal(1, "stream_response_checker: run did not pass");
                end
            end
        end
    end
`endif
`else
    // Default build: the harness polls done/pass and owns simulation control.
`endif

endmodule

// File: tb/tb_stream_response_checker.sv
// tb/tb_stream_response_checker.sv - directed vector bench for stream_response_checker

module tb_stream_response_checker;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        a_start = 1'b0;
    logic        b_start = 1'b0;

    logic        a_done, a_pass, a_to;
    logic [7:0]  a_err;
    logic [15:0] a_fei, a_bc;
    logic        b_done, b_pass, b_to;
    logic [7:0]  b_err;
    logic [15:0] b_fei, b_bc;

    int n_checks = 0;
    int n_fail   = 0;

    stream_response_checker_if #(.WIDTH(8)) a_if ();
    stream_response_checker_if #(.WIDTH(8)) b_if ();

    stream_response_checker #(
        .WIDTH(8), .COUNT(16), .SEED(0), .STEP(1), .TIMEOUT(8)
    ) dut_a (
        .clock(clock), .reset(reset), .start(a_start), .in_stream(a_if),
        .done(a_done), .pass(a_pass), .timed_out(a_to), .err_count(a_err),
        .first_err_idx(a_fei), .beat_count(a_bc)
    );

    stream_response_checker #(
        .WIDTH(8), .COUNT(300), .SEED(8'hFE), .STEP(1), .TIMEOUT(8)
    ) dut_b (
        .clock(clock), .reset(reset), .start(b_start), .in_stream(b_if),
        .done(b_done), .pass(b_pass), .timed_out(b_to), .err_count(b_err),
        .first_err_idx(b_fei), .beat_count(b_bc)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic        rst_n;
        logic        start;
        logic        valid;
        logic [7:0]  bits;
        logic        e_ready;
        logic        e_done;
        logic        e_pass;
        logic        e_to;
        logic [7:0]  e_err;
        logic [15:0] e_fei;
        logic [15:0] e_bc;
    } vec_t;

    vec_t vecs [20];

    function automatic vec_t mk(input logic r, input logic s, input logic v, input logic [7:0] d,
                                input logic rdy, input logic dn, input logic ps, input logic to,
                                input logic [7:0] er, input logic [15:0] fe, input logic [15:0] bc);
        vec_t x;
        x.rst_n = r; x.start = s; x.valid = v; x.bits = d;
        x.e_ready = rdy; x.e_done = dn; x.e_pass = ps; x.e_to = to;
        x.e_err = er; x.e_fei = fe; x.e_bc = bc;
        return x;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Drive inputs away from the edge, then sample just after the edge.
    task automatic step_a(input logic r, input logic s, input logic v, input logic [7:0] d);
        @(negedge clock);
        reset = r; a_start = s; a_if.in_valid = v; a_if.in_bits = d;
        @(posedge clock);
        #1;
    endtask

    task automatic check_a(input string tag, input logic rdy, input logic dn, input logic ps,
                           input logic to, input logic [7:0] er, input logic [15:0] fe,
                           input logic [15:0] bc);
        check({tag, ".in_ready"},      32'(a_if.in_ready), 32'(rdy));
        check({tag, ".done"},          32'(a_done), 32'(dn));
        check({tag, ".pass"},          32'(a_pass), 32'(ps));
        check({tag, ".timed_out"},     32'(a_to), 32'(to));
        check({tag, ".err_count"},     32'(a_err), 32'(er));
        check({tag, ".first_err_idx"}, 32'(a_fei), 32'(fe));
        check({tag, ".beat_count"},    32'(a_bc), 32'(bc));
    endtask

    // Start a run from IDLE/DONE and feed 16 correct beats; optional bubble before each beat.
    task automatic clean_run(input bit throttle, input string tag);
        step_a(1'b1, 1'b1, 1'b0, 8'h00);
        check_a({tag, ".start"}, 1'b1, 1'b0, 1'b0, 1'b0, 8'd0, 16'hFFFF, 16'd0);
        for (int i = 0; i < 16; i++) begin
            if (throttle) begin
                step_a(1'b1, 1'b0, 1'b0, 8'h00);
            end
            step_a(1'b1, 1'b0, 1'b1, 8'(i));
            if (i == 14) begin
                check({tag, ".done_before_last"}, 32'(a_done), 32'd0);
                check({tag, ".bc_before_last"},   32'(a_bc), 32'd15);
            end
        end
        check_a({tag, ".end"}, 1'b0, 1'b1, 1'b1, 1'b0, 8'd0, 16'hFFFF, 16'd16);
        step_a(1'b1, 1'b0, 1'b0, 8'h00);
    endtask

    initial begin
        logic [7:0] exp_b;
        int         idle_cycles;

        a_if.in_valid = 1'b0; a_if.in_bits = 8'h00;
        b_if.in_valid = 1'b0; b_if.in_bits = 8'h00;

        // Reset, ignored valid in IDLE, start, 16 beats with beat 5 corrupted and a
        // start pulse during RUN that must be ignored, then a hold cycle in DONE.
        vecs[0] = mk(1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0, 16'hFFFF, 16'd0);
        vecs[1] = mk(1'b1, 1'b0, 1'b1, 8'h03, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0, 16'hFFFF, 16'd0);
        vecs[2] = mk(1'b1, 1'b1, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 8'd0, 16'hFFFF, 16'd0);
        for (int i = 0; i < 16; i++) begin
            vecs[3 + i] = mk(1'b1, (i == 2), 1'b1, (i == 5) ? 8'hAA : 8'(i),
                             (i != 15), (i == 15), 1'b0, 1'b0,
                             (i >= 5) ? 8'd1 : 8'd0, (i >= 5) ? 16'd5 : 16'hFFFF, 16'(i + 1));
        end
        vecs[19] = mk(1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 8'd1, 16'd5, 16'd16);

        for (int i = 0; i < 20; i++) begin
            step_a(vecs[i].rst_n, vecs[i].start, vecs[i].valid, vecs[i].bits);
            check_a($sformatf("vec%0d", i), vecs[i].e_ready, vecs[i].e_done, vecs[i].e_pass,
                    vecs[i].e_to, vecs[i].e_err, vecs[i].e_fei, vecs[i].e_bc);
        end

        // Restart from DONE, back-to-back clean run; throttled run; restart again.
        clean_run(1'b0, "clean");
        clean_run(1'b1, "throttle");
        clean_run(1'b0, "restart");

        // Timeout: three beats then silence; done must appear after exactly 8 idle cycles.
        step_a(1'b1, 1'b1, 1'b0, 8'h00);
        for (int i = 0; i < 3; i++) begin
            step_a(1'b1, 1'b0, 1'b1, 8'(i));
        end
        idle_cycles = 0;
        for (int i = 0; i < 40; i++) begin
            step_a(1'b1, 1'b0, 1'b0, 8'h00);
            idle_cycles++;
            if (a_done) break;
        end
        check("timeout.idle_cycles", 32'(idle_cycles), 32'd8);
        check_a("timeout", 1'b0, 1'b1, 1'b0, 1'b1, 8'd0, 16'hFFFF, 16'd3);

        // Last beat lands on the cycle the idle timer would expire: accept wins.
        step_a(1'b1, 1'b1, 1'b0, 8'h00);
        for (int i = 0; i < 15; i++) begin
            step_a(1'b1, 1'b0, 1'b1, 8'(i));
        end
        for (int i = 0; i < 7; i++) begin
            step_a(1'b1, 1'b0, 1'b0, 8'h00);
        end
        check("race.done_before", 32'(a_done), 32'd0);
        step_a(1'b1, 1'b0, 1'b1, 8'd15);
        check_a("race", 1'b0, 1'b1, 1'b1, 1'b0, 8'd0, 16'hFFFF, 16'd16);

        // Reset after beat 7 aborts the run; valid is then ignored until start.
        step_a(1'b1, 1'b1, 1'b0, 8'h00);
        for (int i = 0; i < 8; i++) begin
            step_a(1'b1, 1'b0, 1'b1, (i == 3) ? 8'h55 : 8'(i));
        end
        check("midreset.bc_before", 32'(a_bc), 32'd8);
        check("midreset.err_before", 32'(a_err), 32'd1);
        step_a(1'b0, 1'b0, 1'b1, 8'h08);
        check_a("midreset", 1'b0, 1'b0, 1'b0, 1'b0, 8'd0, 16'hFFFF, 16'd0);
        for (int i = 0; i < 3; i++) begin
            step_a(1'b1, 1'b0, 1'b1, 8'(i));
        end
        check_a("midreset.ignored", 1'b0, 1'b0, 1'b0, 1'b0, 8'd0, 16'hFFFF, 16'd0);
        step_a(1'b1, 1'b0, 1'b0, 8'h00);

        // Wrap and saturation on the 300-beat instance: every beat inverted.
        @(negedge clock);
        b_start = 1'b1;
        @(posedge clock); #1;
        check("wrap.ready", 32'(b_if.in_ready), 32'd1);
        exp_b = 8'hFE;
        for (int i = 0; i < 300; i++) begin
            @(negedge clock);
            b_start = 1'b0;
            b_if.in_valid = 1'b1;
            b_if.in_bits = ~exp_b;
            exp_b = exp_b + 8'd1;
            @(posedge clock); #1;
            if (i == 2)   check("wrap.err_after_3", 32'(b_err), 32'd3);
            if (i == 254) check("wrap.err_at_255", 32'(b_err), 32'd255);
            if (i == 298) check("wrap.done_early", 32'(b_done), 32'd0);
        end
        @(negedge clock);
        b_if.in_valid = 1'b0;
        check("wrap.done",      32'(b_done), 32'd1);
        check("wrap.pass",      32'(b_pass), 32'd0);
        check("wrap.timed_out", 32'(b_to), 32'd0);
        check("wrap.err_count", 32'(b_err), 32'd255);
        check("wrap.first_err", 32'(b_fei), 32'd0);
        check("wrap.beat_count", 32'(b_bc), 32'd300);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

endmodule
